// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - two-entry valid/ready skid buffer; optional flush port via PIPE_SKID_FLUSH_EN
module pipe_skid_buf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] def_val,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
`ifdef PIPE_SKID_FLUSH_EN
    ,
    input  logic          flush
`endif
);

    // State bits are {s_ready, m_valid}, so both handshake outputs come straight from flops.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b10,
        ST_ONE   = 2'b11,
        ST_TWO   = 2'b01
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          s_fire;
    logic          m_fire;
    logic          load_main_s;
    logic          load_main_skid;
    logic          load_skid;
    logic          flush_w;

`ifdef PIPE_SKID_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign s_fire = s_valid & s_ready;
    assign m_fire = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_s) begin
                main_q <= s_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= s_data;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_s    = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (s_fire) begin
                    load_main_s = 1'b1;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (s_fire && m_fire) begin
                    load_main_s = 1'b1;
                end else if (s_fire) begin
                    load_skid = 1'b1;
                    state_d   = ST_TWO;
                end else if (m_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (m_fire) begin
                    load_main_skid = 1'b1;
                    state_d        = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush only clears occupancy; payload registers may still load harmlessly.
        if (flush_w) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        s_ready = state_q[1];
        m_valid = state_q[0];
        m_data  = m_valid ? main_q : def_val;
    end

endmodule

// File: tb/tb_pipe_skid_buf.sv
// tb/tb_pipe_skid_buf.sv - scoreboard testbench for pipe_skid_buf
module tb_pipe_skid_buf;

    localparam int DW = 32;
    localparam logic [DW-1:0] DEF = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] def_val = DEF;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          flush = 1'b0;

    int            checks = 0;
    int            fails = 0;
    int            recv_cnt = 0;
    logic [DW-1:0] sb[$];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;

    pipe_skid_buf #(.DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .def_val (def_val),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
`ifdef PIPE_SKID_FLUSH_EN
        ,
        .flush   (flush)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: push on s_fire, pop and compare on m_fire, watch stall stability.
    always @(negedge clk) begin
        logic [DW-1:0] exp_v;
        if (rst) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== data_prev) begin
                    fails++;
                    $display("FAIL stall_stable: m_valid=%b m_data=%h required m_valid=1 m_data=%h", m_valid, m_data, data_prev);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                recv_cnt++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got beat %h required no beat", m_data);
                end else begin
                    exp_v = sb.pop_front();
                    if (m_data !== exp_v) begin
                        fails++;
                        $display("FAIL sb_order: m_data=%h required %h", m_data, exp_v);
                    end
                end
            end
            stall_prev = m_valid && !m_ready && !flush;
            data_prev  = m_data;
            if (flush) sb.delete();
            else if (s_valid && s_ready) sb.push_back(s_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; s_data = 32'h77; m_ready = 1'b1;
        tick(); tick();
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
        checks++;
        if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
        checks++;
        if (m_data !== DEF) begin fails++; $display("FAIL reset_m_data: got %h required %h", m_data, DEF); end
        tick(); tick();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_no_beat: m_valid=%b required 0", m_valid); end
        tick();
    endtask

    task automatic test_stream();
        m_ready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            s_valid = (k < 8);
            s_data  = k + 1;
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b1) begin fails++; $display("FAIL stream_s_ready k=%0d: got %b required 1", k, s_ready); end
            if (k >= 1) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== 32'(k)) begin
                    fails++;
                    $display("FAIL stream_latency k=%0d: m_valid=%b m_data=%h required 1/%h", k, m_valid, m_data, k);
                end
            end
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic test_skid();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 32'hA;
        tick();
        s_data = 32'hB;
        @(negedge clk);
        checks++;
        if (m_data !== 32'hA || s_ready !== 1'b1) begin fails++; $display("FAIL skid_one: m_data=%h s_ready=%b required A/1", m_data, s_ready); end
        tick();
        s_data = 32'hC;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || m_data !== 32'hA) begin fails++; $display("FAIL skid_full: s_ready=%b m_data=%h required 0/A", s_ready, m_data); end
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || m_data !== 32'hA) begin fails++; $display("FAIL skid_hold: s_ready=%b m_data=%h required 0/A", s_ready, m_data); end
        tick();
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || m_data !== 32'hB) begin fails++; $display("FAIL skid_second: s_ready=%b m_data=%h required 1/B", s_ready, m_data); end
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'hC) begin fails++; $display("FAIL skid_third: m_valid=%b m_data=%h required 1/C", m_valid, m_data); end
        tick();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin fails++; $display("FAIL skid_empty: m_valid=%b required 0", m_valid); end
        tick();
    endtask

    task automatic test_drain();
        m_ready = 1'b1; s_valid = 1'b1; s_data = 32'h5;
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h5) begin fails++; $display("FAIL drain_beat: m_valid=%b m_data=%h required 1/5", m_valid, m_data); end
        tick();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || m_data !== DEF) begin fails++; $display("FAIL drain_def: m_valid=%b m_data=%h required 0/%h", m_valid, m_data, DEF); end
        tick();
    endtask

    task automatic test_random();
        int sent = 0;
        int cycles = 0;
        int recv_start = recv_cnt;
        logic pending = 1'b0;
        while (sent < 10000 && cycles < 60000) begin
            if (!pending) begin
                s_valid = $urandom_range(1, 0) == 1;
                s_data  = $urandom;
            end
            m_ready = $urandom_range(1, 0) == 1;
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            pending = s_valid && !s_ready;
            tick();
            cycles++;
        end
        checks++;
        if (sent < 10000) begin fails++; $display("FAIL random_timeout: sent %0d required 10000", sent); end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        @(negedge clk);
        checks++;
        if (sb.size() != 0 || (recv_cnt - recv_start) != sent) begin
            fails++;
            $display("FAIL random_count: received %0d left %0d required %0d left 0", recv_cnt - recv_start, sb.size(), sent);
        end
        tick();
    endtask

`ifdef PIPE_SKID_FLUSH_EN
    task automatic test_flush();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h1;
        tick();
        s_data = 32'h2;
        tick();
        s_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0) begin fails++; $display("FAIL flush_pre: m_valid=%b s_ready=%b required 1/0", m_valid, s_ready); end
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== DEF) begin
            fails++;
            $display("FAIL flush_post: m_valid=%b s_ready=%b m_data=%h required 0/1/%h", m_valid, s_ready, m_data, DEF);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0) begin fails++; $display("FAIL flush_leak: m_valid=%b m_data=%h required 0", m_valid, m_data); end
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_drain();
        test_random();
`ifdef PIPE_SKID_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
